// File: rtl/resp_checker_pkg.sv
// Shared types and constants for the netlist response checker.
// Included by the interface, the MISR and the top.
package resp_chk_pkg;

    localparam int unsigned IN_W  = 14;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned CNT_W = 16;

    localparam logic [OUT_W-1:0] MISR_POLY_DEF = 8'hB8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    typedef struct packed {
        logic [IN_W-1:0]  vec;
        logic [OUT_W-1:0] gold;
        logic [OUT_W-1:0] dut;
    } beat_t;

endpackage

// File: rtl/resp_checker_if.sv
// Beat stream plus run control/result bundle between the GA harness (master)
// and the response checker (slave).
interface resp_checker_if;
    import resp_chk_pkg::*;

    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_vec;
    logic [OUT_W-1:0] gold_out;
    logic [OUT_W-1:0] dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mism_cnt;
    logic [IN_W-1:0]  first_fail_vec;
    logic [OUT_W-1:0] first_fail_diff;
    logic [OUT_W-1:0] signature;

    modport master (
        output start, num_vec, in_valid, in_vec, gold_out, dut_out,
        input  in_ready, busy, done, pass, mism_cnt, first_fail_vec, first_fail_diff,
               signature
    );

    modport slave (
        input  start, num_vec, in_valid, in_vec, gold_out, dut_out,
        output in_ready, busy, done, pass, mism_cnt, first_fail_vec, first_fail_diff,
               signature
    );

endinterface

// File: rtl/misr_reg.sv
// Multiple-input signature register: Galois-style shift with feedback taps,
// XOR-ing one data word per enabled cycle. clr_i has priority over en_i.
module misr_reg #(
    parameter int unsigned      OUT_W = 8,
    parameter logic [OUT_W-1:0] POLY  = resp_chk_pkg::MISR_POLY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [OUT_W-1:0] data_i,
    output logic [OUT_W-1:0] sig_o
);

    logic [OUT_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = {sig_q[OUT_W-2:0], 1'b0} ^ (sig_q[OUT_W-1] ? POLY : '0) ^ data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/resp_checker.sv
// Golden-vs-candidate response checker: run FSM, two-stage beat pipeline,
// mismatch counting with first-failure capture, and MISR compaction.
module resp_checker
    import resp_chk_pkg::*;
#(
    parameter logic [OUT_W-1:0] MISR_POLY = MISR_POLY_DEF
) (
    input  logic          clk,
    input  logic          rst,
    resp_checker_if.slave bus
);

    state_e           state_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] acc_cnt_q;
    logic [CNT_W-1:0] mism_cnt_q;
    logic [IN_W-1:0]  ff_vec_q;
    logic [OUT_W-1:0] ff_diff_q;
    beat_t            s1_q;
    logic             s1_valid_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [OUT_W-1:0] signature;

    logic             start_acc;
    logic             accept;
    logic             last_acc;
    logic             mism_hit;
    logic [OUT_W-1:0] s2_diff;

    always_comb begin
        start_acc = bus.start && (state_q == StIdle || state_q == StDone);
        accept    = bus.in_valid && in_ready_q;
        last_acc  = accept && (acc_cnt_q == num_q - CNT_W'(1));
        s2_diff   = s1_q.gold ^ s1_q.dut;
        mism_hit  = s1_valid_q && (s2_diff != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            num_q      <= '0;
            acc_cnt_q  <= '0;
            mism_cnt_q <= '0;
            ff_vec_q   <= '0;
            ff_diff_q  <= '0;
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            // Stage 1: capture the handshaken beat
            s1_valid_q <= accept;
            if (accept) begin
                s1_q      <= '{vec: bus.in_vec, gold: bus.gold_out, dut: bus.dut_out};
                acc_cnt_q <= acc_cnt_q + CNT_W'(1);
            end

            // Stage 2: fold the stage-1 beat into the accumulators
            if (mism_hit) begin
                if (mism_cnt_q != '1) begin
                    mism_cnt_q <= mism_cnt_q + CNT_W'(1);
                end
                if (mism_cnt_q == '0) begin
                    ff_vec_q  <= s1_q.vec;
                    ff_diff_q <= s2_diff;
                end
            end

            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        num_q      <= bus.num_vec;
                        acc_cnt_q  <= '0;
                        mism_cnt_q <= '0;
                        ff_vec_q   <= '0;
                        ff_diff_q  <= '0;
                        if (bus.num_vec == '0) begin
                            state_q    <= StDone;
                            done_q     <= 1'b1;
                            pass_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q    <= StRun;
                            done_q     <= 1'b0;
                            pass_q     <= 1'b0;
                            busy_q     <= 1'b1;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (last_acc) begin
                        state_q    <= StDrain;
                        in_ready_q <= 1'b0;
                    end
                end
                StDrain: begin
                    // The last beat sits in stage 1 now and is absorbed at this edge
                    state_q <= StDone;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= !mism_hit && (mism_cnt_q == '0);
                end
            endcase
        end
    end

    misr_reg #(
        .OUT_W (OUT_W),
        .POLY  (MISR_POLY)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start_acc),
        .en_i   (s1_valid_q),
        .data_i (s1_q.dut),
        .sig_o  (signature)
    );

    assign bus.in_ready        = in_ready_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.mism_cnt        = mism_cnt_q;
    assign bus.first_fail_vec  = ff_vec_q;
    assign bus.first_fail_diff = ff_diff_q;
    assign bus.signature       = signature;

endmodule
